// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: nibble width, FSM state
// encoding and the counter width helper.
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Counter must index NIBBLES positions; a single nibble still needs one bit.
    function automatic int cnt_width(input int nibbles);
        return (nibbles <= 1) ? 1 : $clog2(nibbles);
    endfunction

endpackage

// File: rtl/fourbits_adder.sv
// Combinational N-bit ripple-carry adder, used as the per-nibble datapath.
module fourbits_adder #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         carry_in,
    output logic [N-1:0] sum,
    output logic         carry_out
);

    logic [N:0] carry;

    assign carry[0] = carry_in;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_bit
            assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign carry_out = carry[N];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle W-bit adder: one nibble per clock through a 4-bit ripple adder,
// least significant nibble first, with a start/busy/done handshake.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [4*NIBBLES-1:0]        a,
    input  logic [4*NIBBLES-1:0]        b,
    input  logic                        carry_in,
    output logic                        busy,
    output logic                        done,
    output logic [4*NIBBLES-1:0]        sum,
    output logic                        carry_out
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int CNT_W = cnt_width(NIBBLES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

    state_t            state_reg, state_next;
    logic [W-1:0]      a_sh_reg, a_sh_next;
    logic [W-1:0]      b_sh_reg, b_sh_next;
    logic [W-1:0]      psum_reg, psum_next;
    logic              c_reg, c_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [W-1:0]      sum_reg, sum_next;
    logic              carry_out_reg, carry_out_next;

    logic [NIBBLE_W-1:0] add_sum;
    logic                add_cout;
    logic [W-1:0]        psum_shift;
    logic                load;

    fourbits_adder #(
        .N(NIBBLE_W)
    ) u_nibble_adder (
        .a         (a_sh_reg[NIBBLE_W-1:0]),
        .b         (b_sh_reg[NIBBLE_W-1:0]),
        .carry_in  (c_reg),
        .sum       (add_sum),
        .carry_out (add_cout)
    );

    // New nibble enters at the top; after NIBBLES shifts the word is aligned.
    assign psum_shift = (psum_reg >> NIBBLE_W) | (W'(add_sum) << (W - NIBBLE_W));

    always_comb begin
        state_next     = state_reg;
        a_sh_next      = a_sh_reg;
        b_sh_next      = b_sh_reg;
        psum_next      = psum_reg;
        c_next         = c_reg;
        cnt_next       = cnt_reg;
        sum_next       = sum_reg;
        carry_out_next = carry_out_reg;
        load           = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                a_sh_next = a_sh_reg >> NIBBLE_W;
                b_sh_next = b_sh_reg >> NIBBLE_W;
                psum_next = psum_shift;
                c_next    = add_cout;
                cnt_next  = cnt_reg + CNT_W'(1);
                if (cnt_reg == LAST_CNT) begin
                    sum_next       = psum_shift;
                    carry_out_next = add_cout;
                    state_next     = DONE;
                end
            end
            DONE: begin
                // A start in the done cycle chains straight into the next operation.
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (load) begin
            a_sh_next = a;
            b_sh_next = b;
            c_next    = carry_in;
            cnt_next  = '0;
            psum_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            a_sh_reg      <= '0;
            b_sh_reg      <= '0;
            psum_reg      <= '0;
            c_reg         <= 1'b0;
            cnt_reg       <= '0;
            sum_reg       <= '0;
            carry_out_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            a_sh_reg      <= a_sh_next;
            b_sh_reg      <= b_sh_next;
            psum_reg      <= psum_next;
            c_reg         <= c_next;
            cnt_reg       <= cnt_next;
            sum_reg       <= sum_next;
            carry_out_reg <= carry_out_next;
        end
    end

    assign busy      = (state_reg == RUN);
    assign done      = (state_reg == DONE);
    assign sum       = sum_reg;
    assign carry_out = carry_out_reg;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench: table vectors, multi-cycle corner sequences and a
// random sweep at NIBBLES = 1, 4 and 8 against a plain-arithmetic model.
module tb_nibble_serial_adder;

    logic clk;
    logic rst_n;

    logic        start4, cin4, busy4, done4, cout4;
    logic [15:0] a4, b4, sum4;
    logic        start1, cin1, busy1, done1, cout1;
    logic [3:0]  a1, b1, sum1;
    logic        start8, cin8, busy8, done8, cout8;
    logic [31:0] a8, b8, sum8;

    int errors = 0;
    int checks = 0;
    logic [15:0] last4;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
    } vec_t;

    nibble_serial_adder #(.NIBBLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .carry_in(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .carry_out(cout4)
    );
    nibble_serial_adder #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .carry_in(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .carry_out(cout1)
    );
    nibble_serial_adder #(.NIBBLES(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .carry_in(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .carry_out(cout8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Full NIBBLES=4 transaction starting in the current cycle (cycle 0).
    task automatic run4(input logic [15:0] a, input logic [15:0] b, input logic cin);
        logic [16:0] exp;
        exp = {1'b0, a} + {1'b0, b} + 17'(cin);
        start4 = 1'b1; a4 = a; b4 = b; cin4 = cin;
        tick();
        start4 = 1'b0; a4 = 16'($urandom); b4 = 16'($urandom); cin4 = 1'($urandom);
        for (int k = 1; k <= 4; k++) begin
            chk("busy_run", 64'(busy4), 64'(1));
            chk("done_run", 64'(done4), 64'(0));
            chk("sum_hold_run", 64'(sum4), 64'(last4));
            tick();
        end
        chk("done_pulse", 64'(done4), 64'(1));
        chk("busy_at_done", 64'(busy4), 64'(0));
        chk("sum", 64'(sum4), 64'(exp[15:0]));
        chk("carry_out", 64'(cout4), 64'(exp[16]));
        $display("txn N=4 a=%h b=%h cin=%0d -> sum=%h cout=%0d", a, b, cin, sum4, cout4);
        last4 = exp[15:0];
        tick();
        chk("done_drop", 64'(done4), 64'(0));
    endtask

    initial begin
        vec_t        tbl[4];
        logic [16:0] exp_bb[4];
        logic [16:0] exp_ig;
        logic [32:0] exp8;
        logic [4:0]  exp1;
        int          lat;

        tbl[0] = '{a: 16'h1234, b: 16'h0FCD, cin: 1'b0, sum: 16'h2201, cout: 1'b0};
        tbl[1] = '{a: 16'hFFFF, b: 16'h0001, cin: 1'b0, sum: 16'h0000, cout: 1'b1};
        tbl[2] = '{a: 16'hFFFF, b: 16'hFFFF, cin: 1'b1, sum: 16'hFFFF, cout: 1'b1};
        tbl[3] = '{a: 16'h0000, b: 16'h0000, cin: 1'b1, sum: 16'h0001, cout: 1'b0};

        rst_n = 1'b0;
        start4 = 0; a4 = 0; b4 = 0; cin4 = 0;
        start1 = 0; a1 = 0; b1 = 0; cin1 = 0;
        start8 = 0; a8 = 0; b8 = 0; cin8 = 0;
        last4 = 16'h0000;
        tick();
        tick();
        chk("rst_busy", 64'(busy4), 64'(0));
        chk("rst_done", 64'(done4), 64'(0));
        chk("rst_sum", 64'(sum4), 64'(0));
        chk("rst_cout", 64'(cout4), 64'(0));
        rst_n = 1'b1;
        tick();

        // Table vectors with the expected result written out by hand.
        for (int i = 0; i < 4; i++) begin
            run4(tbl[i].a, tbl[i].b, tbl[i].cin);
            chk("tbl_sum", 64'(sum4), 64'(tbl[i].sum));
            chk("tbl_cout", 64'(cout4), 64'(tbl[i].cout));
        end

        // start pulses in cycles 2 and 3 must be ignored.
        exp_ig = {1'b0, 16'h0F0F} + {1'b0, 16'h1111};
        for (int cyc = 0; cyc <= 7; cyc++) begin
            chk("ign_busy", 64'(busy4), 64'((cyc >= 1 && cyc <= 4) ? 1 : 0));
            chk("ign_done", 64'(done4), 64'((cyc == 5) ? 1 : 0));
            chk("ign_sum", 64'(sum4), 64'((cyc >= 5) ? exp_ig[15:0] : last4));
            if (cyc == 0) begin
                start4 = 1; a4 = 16'h0F0F; b4 = 16'h1111; cin4 = 0;
            end else if (cyc == 2 || cyc == 3) begin
                start4 = 1; a4 = 16'hFFFF; b4 = 16'hFFFF; cin4 = 1;
            end else begin
                start4 = 0;
            end
            tick();
        end
        chk("ign_cout", 64'(cout4), 64'(exp_ig[16]));
        $display("txn N=4 ignore-while-busy sum=%h cout=%0d", sum4, cout4);
        last4 = exp_ig[15:0];

        // start held high: completions every 5 cycles, sum stable in between.
        for (int cyc = 0; cyc <= 15; cyc++) begin
            if (cyc > 0 && cyc % 5 == 0) begin
                chk("bb_done", 64'(done4), 64'(1));
                chk("bb_sum", 64'(sum4), 64'(exp_bb[cyc / 5 - 1][15:0]));
                chk("bb_cout", 64'(cout4), 64'(exp_bb[cyc / 5 - 1][16]));
                $display("txn N=4 back-to-back #%0d sum=%h cout=%0d", cyc / 5, sum4, cout4);
                last4 = exp_bb[cyc / 5 - 1][15:0];
            end else begin
                chk("bb_nodone", 64'(done4), 64'(0));
                chk("bb_stable", 64'(sum4), 64'(last4));
            end
            start4 = 1; a4 = 16'($urandom); b4 = 16'($urandom); cin4 = 1'($urandom);
            if (cyc % 5 == 0)
                exp_bb[cyc / 5] = {1'b0, a4} + {1'b0, b4} + 17'(cin4);
            tick();
        end
        start4 = 0;
        for (int k = 16; k < 20; k++) begin
            chk("bb_tail_busy", 64'(busy4), 64'(1));
            tick();
        end
        chk("bb_last_done", 64'(done4), 64'(1));
        chk("bb_last_sum", 64'(sum4), 64'(exp_bb[3][15:0]));
        chk("bb_last_cout", 64'(cout4), 64'(exp_bb[3][16]));
        $display("txn N=4 back-to-back #4 sum=%h cout=%0d", sum4, cout4);
        last4 = exp_bb[3][15:0];
        tick();

        // Asynchronous reset in the middle of an operation.
        run4(16'h8888, 16'h8889, 1'b0);
        start4 = 1; a4 = 16'h4321; b4 = 16'h1111; cin4 = 1;
        tick();
        start4 = 0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy4), 64'(0));
        chk("mid_rst_done", 64'(done4), 64'(0));
        chk("mid_rst_sum", 64'(sum4), 64'(0));
        chk("mid_rst_cout", 64'(cout4), 64'(0));
        tick();
        tick();
        rst_n = 1'b1;
        last4 = 16'h0000;
        for (int cyc = 4; cyc < 6; cyc++) begin
            chk("post_rst_done", 64'(done4), 64'(0));
            chk("post_rst_busy", 64'(busy4), 64'(0));
            tick();
        end
        run4(16'hBEEF, 16'h1234, 1'b1);

        // Random sweep at NIBBLES = 1.
        for (int i = 0; i < 1000; i++) begin
            a1 = 4'($urandom); b1 = 4'($urandom); cin1 = 1'($urandom);
            exp1 = {1'b0, a1} + {1'b0, b1} + 5'(cin1);
            start1 = 1;
            lat = 0;
            tick();
            start1 = 0;
            lat++;
            while (!done1 && lat < 20) begin
                tick();
                lat++;
            end
            chk("n1_latency", 64'(lat), 64'(2));
            chk("n1_result", 64'({cout1, sum1}), 64'(exp1));
            $display("txn N=1 a=%h b=%h cin=%0d -> sum=%h cout=%0d lat=%0d", a1, b1, cin1, sum1, cout1, lat);
            tick();
        end

        // Random sweep at NIBBLES = 8.
        for (int i = 0; i < 1000; i++) begin
            a8 = $urandom; b8 = $urandom; cin8 = 1'($urandom);
            exp8 = {1'b0, a8} + {1'b0, b8} + 33'(cin8);
            start8 = 1;
            lat = 0;
            tick();
            start8 = 0;
            lat++;
            while (!done8 && lat < 30) begin
                tick();
                lat++;
            end
            chk("n8_latency", 64'(lat), 64'(9));
            chk("n8_result", 64'({cout8, sum8}), 64'(exp8));
            $display("txn N=8 a=%h b=%h cin=%0d -> sum=%h cout=%0d lat=%0d", a8, b8, cin8, sum8, cout8, lat);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle adder for W = 4*NIBBLES bit operands, built on the existing combinational 4-bit ripple-carry adder `fourbits_adder`.
- Processes one nibble per clock, least significant nibble first, and registers the carry between nibbles.
- Sits directly upstream of `fourbits_adder`: it feeds the adder's operands and carry-in, then captures its sum and carry-out.
- Gives the lab datapath wide additions with a start/busy/done handshake instead of a W-bit ripple chain.

Parameters:
- NIBBLES, default 4: number of 4-bit nibbles per operand. Operand width W = 4*NIBBLES. Legal range is 1 to 16.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous reset, active-low. Assertion resets all state immediately; release is synchronous to clk.
- start, input, 1: request a new addition. Sampled on the rising edge of clk.
- a, input, W: operand A. Sampled only on the edge where start is accepted.
- b, input, W: operand B. Sampled only on the edge where start is accepted.
- carry_in, input, 1: initial carry. Sampled only on the edge where start is accepted.
- busy, output, 1: high while nibbles are being processed.
- done, output, 1: one-cycle pulse; the result is valid.
- sum, output, W: registered result. Held stable between completions.
- carry_out, output, 1: registered final carry. Held stable with sum.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - busy, done, sum and carry_out = 0.
  - Internal operand, partial-sum, carry and count registers = 0.
- States:
  - IDLE: if start = 1, do the load, then go to RUN.
  - RUN: process one nibble per cycle. After the NIBBLES-th nibble, go to DONE.
  - DONE: lasts one cycle. If start = 1, do the load and go to RUN; otherwise go to IDLE.
- Load, on the accepting edge:
  - a_sh = a, b_sh = b, c = carry_in, cnt = 0.
  - The partial-sum shift register is cleared.
- RUN cycle, per edge:
  - Drive the adder with a_sh[3:0], b_sh[3:0] and c.
  - Shift the adder's 4-bit sum into the top of the partial-sum register, which shifts right by 4.
  - Shift a_sh and b_sh right by 4, zero-filling.
  - c = adder carry_out; cnt = cnt + 1.
- Completion: on the edge where cnt = NIBBLES-1 in RUN:
  - sum = the final partial-sum including this nibble.
  - carry_out = the adder carry_out.
  - Both are loaded in the same edge; the state goes to DONE.
- Output decodes (registered or decoded from state):
  - busy = 1 exactly when state = RUN.
  - done = 1 exactly when state = DONE.
- Latency: start high in cycle 0 gives busy high in cycles 1..NIBBLES and done high in cycle NIBBLES+1. For NIBBLES = 4, done is in cycle 5.
- Throughput: with start held high, back-to-back operations are accepted every NIBBLES+1 cycles.
- start while busy = 1 is ignored. There is no queueing and no error flag.
- start in the DONE cycle is accepted. That cycle still shows done = 1, and busy rises next cycle.
- sum and carry_out change only on a completion edge or on reset. They are never disturbed mid-operation.
- Arithmetic: unsigned modulo 2^W; carry_out is bit W of a + b + carry_in. No signed overflow output.
- Reset mid-operation: the operation is abandoned, no done is produced, and sum/carry_out return to 0.
- Counter width: clog2(NIBBLES) bits, minimum 1. cnt never wraps within RUN.

Decomposition:
- Shared package holds:
  - NIBBLE_W = 4.
  - The state encoding: IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10.
  - A width function for the counter.
- One sub-module: the existing `fourbits_adder`, instantiated once as the nibble datapath with its N parameter set to NIBBLE_W.
- FSM, shift registers and result registers live in nibble_serial_adder.

Test Plan:
- Basic add, NIBBLES = 4: start with a = 16'h1234, b = 16'h0FCD, carry_in = 0 in cycle 0 -> busy high cycles 1-4, done cycle 5, sum = 16'h2201, carry_out = 0.
- Carry ripple across nibbles: a = 16'hFFFF, b = 16'h0001, carry_in = 0 -> sum = 16'h0000, carry_out = 1. Then a = 16'hFFFF, b = 16'hFFFF, carry_in = 1 -> sum = 16'hFFFF, carry_out = 1.
- start ignored during busy: start pulses in cycles 2 and 3 carrying different operands -> a single done in cycle 5, with the result of the cycle-0 operands only.
- Back-to-back: start held high continuously -> done in cycles 5, 10, 15. Each result matches the operands present on its accepting edge, and sum stays stable between done pulses.
- Reset mid-operation: rst_n low asynchronously in cycle 2, high in cycle 4 -> busy, done, sum and carry_out go to 0 immediately. No done appears, and a new start in cycle 6 completes normally in cycle 11.
- Parameter sweep: NIBBLES = 1 and NIBBLES = 8 with random operands -> done latency is NIBBLES+1 and {carry_out, sum} equals a + b + carry_in across 1000 random vectors.
